if_id_buf: RTL

IF_ID_BUF -- requirements
Module: if_id_buf

---
 rtl/if_id_buf_pkg.sv | 22 ++
 rtl/inst_fifo.sv | 48 ++++
 rtl/if_id_buf.sv | 80 ++++++++
 3 files changed

// File: rtl/if_id_buf_pkg.sv
// Shared widths, hold codes and the NOP encoding
// used by the fetch/decode boundary.
package if_id_buf_pkg;

    localparam int HOLD_W = 3;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [HOLD_W-1:0] Hold_None = 3'd0;
    localparam logic [HOLD_W-1:0] Hold_PC   = 3'd1;
    localparam logic [HOLD_W-1:0] Hold_PPL  = 3'd2;

    localparam logic [DATA_W-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } fetch_t;

    localparam int FETCH_W = $bits(fetch_t);

endpackage

// File: rtl/inst_fifo.sv
// Two-entry skid FIFO with flush; storage
// is not reset, only pointers and count.
module inst_fifo #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   cnt
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop && (cnt != 2'd0);
    assign do_push = push && ((cnt != 2'd2) || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap modulo 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Entry storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/if_id_buf.sv
// IF/ID boundary: skid FIFO absorbing fetches during
// pipeline holds, followed by the decode-facing register.
module if_id_buf
    import if_id_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [HOLD_W-1:0] hold_flag,
    input  logic              jump_flag,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic [DATA_W-1:0] inst_data_i,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              inst_valid_o,
    output logic              buf_full_o,
    output logic [1:0]        buf_cnt_o
);

    logic   in_vld;
    logic   adv;
    logic   empty;
    logic   pop;
    logic   bypass;
    logic   push;
    logic   room;
    fetch_t in_f;
    fetch_t head;
    logic [1:0] cnt;

    assign in_vld = (inst_data_i != '0);
    assign adv    = (hold_flag != Hold_PPL) && !jump_flag;
    assign empty  = (cnt == 2'd0);
    assign pop    = adv && !empty;
    assign bypass = adv && empty && in_vld;
    assign room   = (cnt != 2'd2) || pop;
    assign push   = in_vld && !jump_flag && !bypass && room;

    assign in_f.addr = inst_addr_i;
    assign in_f.data = inst_data_i;

    assign buf_full_o = (cnt == 2'd2);
    assign buf_cnt_o  = cnt;

    inst_fifo #(.W(FETCH_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (jump_flag),
        .din   (in_f),
        .dout  (head),
        .cnt   (cnt)
    );

    // Decode-facing register: flush, then FIFO head, bypass or bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_o       <= INST_NOP;
            inst_addr_o  <= '0;
            inst_valid_o <= 1'b0;
        end else if (jump_flag) begin
            inst_o       <= INST_NOP;
            inst_valid_o <= 1'b0;
        end else if (adv) begin
            if (!empty) begin
                inst_o       <= head.data;
                inst_addr_o  <= head.addr;
                inst_valid_o <= 1'b1;
            end else if (in_vld) begin
                inst_o       <= inst_data_i;
                inst_addr_o  <= inst_addr_i;
                inst_valid_o <= 1'b1;
            end else begin
                inst_o       <= INST_NOP;
                inst_valid_o <= 1'b0;
            end
        end
    end

endmodule
